// File: rtl/neuron_mac_if.sv
// Stream handshake bundle for neuron_mac: an 8-bit input/weight beat stream in,
// one rounded 8-bit activation out.
interface neuron_mac_if #(
  parameter int MAX_TERMS = 32
);
  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       x;
  logic [7:0]       w;
  logic             in_last;
  logic [7:0]       bias;

  logic             out_valid;
  logic             out_ready;
  logic [7:0]       y;
  logic             sat;
  logic [CNT_W-1:0] n_terms;

  modport master (
    output in_valid, x, w, in_last, bias, out_ready,
    input  in_ready, out_valid, y, sat, n_terms
  );

  modport slave (
    input  in_valid, x, w, in_last, bias, out_ready,
    output in_ready, out_valid, y, sat, n_terms
  );
endinterface

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate for one neuron: sums signed Q1.7 products in a
// wide accumulator, adds the bias, then rounds half-up and saturates back to Q1.7.
module neuron_mac #(
  parameter int ACC_W     = 20,
  parameter int MAX_TERMS = 32
) (
  input  logic        clk,
  input  logic        rst,
  neuron_mac_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(MAX_TERMS);
  localparam logic signed [ACC_W:0] Y_MAX    = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] Y_MIN    = (ACC_W+1)'(-128);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FINISH,
    ST_OUT
  } state_t;

  state_t state, state_next;

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic signed [7:0]       bias_r;
  logic [7:0]              y_r;
  logic                    sat_r;
  logic [CNT_W-1:0]        n_terms_r;

  logic                    accept;
  logic                    out_fire;
  logic                    beat_last;
  logic [CNT_W-1:0]        beat_num;
  logic signed [15:0]      x_ext;
  logic signed [15:0]      w_ext;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W:0]   acc_wide;
  logic signed [ACC_W:0]   bias_wide;
  logic signed [ACC_W:0]   sum_fin;
  logic signed [ACC_W:0]   shifted;
  logic signed [ACC_W:0]   rnd;
  logic [7:0]              y_next;
  logic                    sat_next;

  assign bus.in_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.y         = y_r;
  assign bus.sat       = sat_r;
  assign bus.n_terms   = n_terms_r;

  assign accept   = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  // Full Q2.14 product; the extreme -128*-128 = 16384 still fits in 16 signed bits.
  assign x_ext    = 16'($signed(bus.x));
  assign w_ext    = 16'($signed(bus.w));
  assign prod     = x_ext * w_ext;
  assign prod_ext = ACC_W'(prod);

  // Position of the beat being offered within its vector; the MAX_TERMS-th beat
  // closes the vector regardless of in_last.
  assign beat_num  = (state == ST_IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
  assign beat_last = bus.in_last || (beat_num == LAST_CNT);

  // Bias is aligned to the Q.14 product scale; one extra bit keeps the sum exact.
  assign acc_wide  = (ACC_W+1)'(acc);
  assign bias_wide = (ACC_W+1)'(bias_r) <<< 7;
  assign sum_fin   = acc_wide + bias_wide;
  assign shifted   = sum_fin >>> 7;
  assign rnd       = shifted + (ACC_W+1)'(sum_fin[6]);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    y_next   = rnd[7:0];
    sat_next = 1'b0;
    if (rnd > Y_MAX) begin
      y_next   = 8'h7F;
      sat_next = 1'b1;
    end else if (rnd < Y_MIN) begin
      y_next   = 8'h80;
      sat_next = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = beat_last ? ST_FINISH : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept && beat_last) begin
          state_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_next = ST_OUT;
      end
      ST_OUT: begin
        if (out_fire) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      bias_r    <= '0;
      y_r       <= '0;
      sat_r     <= 1'b0;
      n_terms_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc    <= prod_ext;
            bias_r <= $signed(bus.bias);
            cnt    <= beat_num;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            acc <= acc + prod_ext;
            cnt <= beat_num;
          end
        end
        ST_FINISH: begin
          y_r       <= y_next;
          sat_r     <= sat_next;
          n_terms_r <= cnt;
        end
        ST_OUT: begin
          // Result registers stay put after the handshake; only the sum is cleared.
          if (out_fire) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        default: begin
          acc <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: directed vector table, multi-cycle corner sequences and
// randomized vectors scored against an integer round-half-up model.
module tb_neuron_mac;

  localparam int ACC_W     = 20;
  localparam int MAX_TERMS = 32;

  logic clk = 1'b0;
  logic rst;

  neuron_mac_if #(.MAX_TERMS(MAX_TERMS)) bus ();

  neuron_mac #(.ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] x;
    logic [7:0] w;
    logic [7:0] bias;
    int         beats;
    logic [7:0] ey;
    logic       es;
  } vec_t;

  vec_t       tbl [11];
  logic [7:0] xs [MAX_TERMS];
  logic [7:0] ws [MAX_TERMS];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Integer reference: total = sum(x*w) + bias*128, then floor((total+64)/128), clamp.
  function automatic void model(input int total, output logic [7:0] y, output logic s);
    int n;
    int q;
    n = total + 64;
    q = n / 128;
    if ((n % 128 != 0) && (n < 0)) q = q - 1;
    s = 1'b0;
    if (q > 127) begin
      q = 127;
      s = 1'b1;
    end else if (q < -128) begin
      q = -128;
      s = 1'b1;
    end
    y = q[7:0];
  endfunction

  task automatic send_beat(input logic [7:0] x, input logic [7:0] w, input logic last,
                           input logic [7:0] bias);
    int wait_n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x        = x;
    bus.w        = w;
    bus.in_last  = last;
    bus.bias     = bias;
    while (!bus.in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (wait_n == 50) check("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic bubble();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic end_beats();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [7:0] ey, input logic es,
                            input int en, input int hold);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      check({name, "_timeout"}, 32'(bus.out_valid), 32'd1);
    end else begin
      check({name, "_y"}, 32'(bus.y), 32'(ey));
      check({name, "_sat"}, 32'(bus.sat), 32'(es));
      check({name, "_n"}, 32'(bus.n_terms), 32'(en));
      if (hold > 0) begin
        repeat (hold) @(negedge clk);
        check({name, "_hold_y"}, 32'(bus.y), 32'(ey));
        check({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({name, "_drop"}, 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    int         n;
    int         total;
    int         accepts;
    logic       final_last;
    logic [7:0] bias_v;
    logic [7:0] ey;
    logic       es;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.w         = '0;
    bus.in_last   = 1'b0;
    bus.bias      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_sat", 32'(bus.sat), 32'd0);
    check("rst_n", 32'(bus.n_terms), 32'd0);

    // Single beat with latency probe: result visible two cycles after the accept edge.
    send_beat(8'h40, 8'h40, 1'b1, 8'h00);
    end_beats();
    check("lat_cycle1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2", 32'(bus.out_valid), 32'd1);
    get_result("single", 8'h20, 1'b0, 1, 0);

    tbl[0]  = '{x: 8'h01, w: 8'h40, bias: 8'h00, beats: 1, ey: 8'h01, es: 1'b0};
    tbl[1]  = '{x: 8'h01, w: 8'h3F, bias: 8'h00, beats: 1, ey: 8'h00, es: 1'b0};
    tbl[2]  = '{x: 8'hFF, w: 8'h40, bias: 8'h00, beats: 1, ey: 8'h00, es: 1'b0};
    tbl[3]  = '{x: 8'hFF, w: 8'h41, bias: 8'h00, beats: 1, ey: 8'hFF, es: 1'b0};
    tbl[4]  = '{x: 8'h00, w: 8'h00, bias: 8'h10, beats: 1, ey: 8'h10, es: 1'b0};
    tbl[5]  = '{x: 8'h7F, w: 8'h7F, bias: 8'h00, beats: 4, ey: 8'h7F, es: 1'b1};
    tbl[6]  = '{x: 8'h80, w: 8'h7F, bias: 8'h00, beats: 4, ey: 8'h80, es: 1'b1};
    tbl[7]  = '{x: 8'h80, w: 8'h80, bias: 8'h00, beats: 1, ey: 8'h7F, es: 1'b1};
    tbl[8]  = '{x: 8'h00, w: 8'h00, bias: 8'h80, beats: 1, ey: 8'h80, es: 1'b0};
    tbl[9]  = '{x: 8'h40, w: 8'h01, bias: 8'h01, beats: 1, ey: 8'h02, es: 1'b0};
    tbl[10] = '{x: 8'h10, w: 8'h10, bias: 8'hFF, beats: 3, ey: 8'h05, es: 1'b0};

    for (int i = 0; i < 11; i++) begin
      for (int b = 0; b < tbl[i].beats; b++) begin
        send_beat(tbl[i].x, tbl[i].w, (b == tbl[i].beats - 1), tbl[i].bias);
      end
      end_beats();
      get_result($sformatf("tbl%0d", i), tbl[i].ey, tbl[i].es, tbl[i].beats, i % 3);
    end

    // Backpressure: beats offered while the result waits must not be consumed.
    send_beat(8'h40, 8'h20, 1'b1, 8'h00);
    end_beats();
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1;
    bus.x        = 8'h7F;
    bus.w        = 8'h7F;
    bus.in_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_y", 32'(bus.y), 32'h10);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_drop", 32'(bus.out_valid), 32'd0);
    bus.x       = 8'h40;
    bus.w       = 8'h40;
    bus.in_last = 1'b1;
    @(posedge clk);
    end_beats();
    get_result("bp_next", 8'h20, 1'b0, 1, 0);

    // Forced termination at MAX_TERMS, then the next beat opens a fresh vector.
    for (int i = 0; i < MAX_TERMS; i++) send_beat(8'h01, 8'h7F, 1'b0, 8'h00);
    end_beats();
    check("forced_in_ready", 32'(bus.in_ready), 32'd0);
    get_result("forced", 8'h20, 1'b0, 32, 2);
    send_beat(8'h01, 8'h7F, 1'b0, 8'h00);
    send_beat(8'h01, 8'h7F, 1'b1, 8'h00);
    end_beats();
    get_result("after_forced", 8'h02, 1'b0, 2, 0);

    // Reset after three of five beats.
    for (int i = 0; i < 3; i++) send_beat(8'h7F, 8'h7F, 1'b0, 8'h20);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_y", 32'(bus.y), 32'd0);
    check("mid_rst_sat", 32'(bus.sat), 32'd0);
    check("mid_rst_n", 32'(bus.n_terms), 32'd0);
    rst = 1'b0;
    send_beat(8'h40, 8'h40, 1'b1, 8'h00);
    end_beats();
    get_result("post_rst", 8'h20, 1'b0, 1, 0);

    // Minimum period: 1-beat vectors with out_ready tied high accept every third cycle.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.x         = 8'h40;
    bus.w         = 8'h40;
    bus.in_last   = 1'b1;
    bus.bias      = 8'h00;
    bus.out_ready = 1'b1;
    accepts       = 0;
    repeat (12) begin
      if (bus.in_ready) accepts++;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    check("min_period_accepts", 32'(accepts), 32'd4);
    check("min_period_idle", 32'(bus.in_ready), 32'd1);

    // Randomized vectors against the integer model.
    for (int v = 0; v < 40; v++) begin
      n          = $urandom_range(1, MAX_TERMS);
      bias_v     = 8'($urandom);
      final_last = !((n == MAX_TERMS) && ($urandom_range(0, 1) == 1));
      total      = int'($signed(bias_v)) * 128;
      for (int i = 0; i < n; i++) begin
        xs[i] = 8'($urandom);
        ws[i] = 8'($urandom);
        total = total + int'($signed(xs[i])) * int'($signed(ws[i]));
      end
      model(total, ey, es);
      for (int i = 0; i < n; i++) begin
        // Bias on later beats is junk; only the first accepted beat's bias counts.
        send_beat(xs[i], ws[i], (i == n - 1) ? final_last : 1'b0,
                  (i == 0) ? bias_v : 8'($urandom));
        if ((i < n - 1) && ($urandom_range(0, 4) == 0)) bubble();
      end
      end_beats();
      get_result($sformatf("rand%0d", v), ey, es, n, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
